// File: rtl/i2c_pkg.sv
// i2c_pkg: state encoding and constants shared by the I2C target and controller.
package i2c_pkg;
    localparam int ADDR_W = 7;
    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ = 1'b1;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WR_DATA,
        ST_WR_ACK,
        ST_RD_DATA,
        ST_RD_ACK,
        ST_IGNORE
    } i2c_state_e;
endpackage

// File: rtl/i2c_target_if.sv
// i2c_target_if: I2C pins plus the byte strobe interface to local register logic.
interface i2c_target_if;
    logic       scl_in;
    logic       sda_in;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_req;
    logic       busy;
    logic       start_det;
    logic       stop_det;
    modport slave (
        input  scl_in, sda_in, tx_data,
        output sda_oe, rx_data, rx_valid, tx_req, busy, start_det, stop_det
    );
    modport master (
        output scl_in, sda_in, tx_data,
        input  sda_oe, rx_data, rx_valid, tx_req, busy, start_det, stop_det
    );
endinterface

// File: rtl/i2c_bus_sync.sv
// i2c_bus_sync: synchronises SCL/SDA and flags SCL edges plus START/STOP conditions.
module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic scl_in,
    input  logic sda_in,
    output logic scl_s,
    output logic sda_s,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);
    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
    logic scl_hist_q, sda_hist_q;
    always_comb begin
        scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_in};
        sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_in};
    end
    // Idle bus level is high, so resetting to 1 avoids a false edge after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_hist_q <= 1'b1;
            sda_hist_q <= 1'b1;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_hist_q <= scl_s;
            sda_hist_q <= sda_s;
        end
    end
    assign scl_s     = scl_sync_q[SYNC_STAGES-1];
    assign sda_s     = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_hist_q;
    assign scl_fall  = ~scl_s & scl_hist_q;
    assign start_det = scl_s & ~sda_s & sda_hist_q;
    assign stop_det  = scl_s & sda_s & ~sda_hist_q;
endmodule

// File: rtl/i2c_target.sv
// i2c_target: 7-bit addressed I2C responder moving bytes over rx/tx strobes.
// Open-drain SDA only; SCL is never driven or stretched.
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [ADDR_W-1:0] ADDR = 7'h50,
    parameter int SYNC_STAGES = 2
) (
    input logic clk,
    input logic rst_n,
    i2c_target_if.slave bus
);
    logic scl_s, sda_s, scl_rise, scl_fall, start, stop, sample, tx_load;
    i2c_state_e state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d, rx_data_q, rx_data_d;
    logic rw_q, rw_d, sda_oe_q, sda_oe_d, busy_q, busy_d, rx_valid_q, rx_valid_d;

    i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk(clk), .rst_n(rst_n), .scl_in(bus.scl_in), .sda_in(bus.sda_in),
        .scl_s(scl_s), .sda_s(sda_s), .scl_rise(scl_rise), .scl_fall(scl_fall),
        .start_det(start), .stop_det(stop)
    );

    assign sample = scl_rise & scl_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= 3'd7;
            shift_q    <= 8'h00;
            rx_data_q  <= 8'h00;
            rw_q       <= RW_WRITE;
            sda_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            rx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            rx_data_q  <= rx_data_d;
            rw_q       <= rw_d;
            sda_oe_q   <= sda_oe_d;
            busy_q     <= busy_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        rx_data_d  = rx_data_q;
        rw_d       = rw_q;
        sda_oe_d   = sda_oe_q;
        busy_d     = busy_q;
        rx_valid_d = 1'b0;
        if (stop) begin
            state_d  = ST_IDLE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else if (start) begin
            state_d   = ST_ADDR;
            bit_cnt_d = 3'd7;
            sda_oe_d  = 1'b0;
        end else if (tx_load) begin
            state_d   = ST_RD_DATA;
            shift_d   = bus.tx_data;
            bit_cnt_d = 3'd7;
            sda_oe_d  = ~bus.tx_data[7];
        end else begin
            case (state_q)
                ST_ADDR: if (sample) begin
                    shift_d   = {shift_q[6:0], sda_s};
                    bit_cnt_d = bit_cnt_q - 3'd1;
                    if (bit_cnt_q == 3'd0) begin
                        rw_d    = sda_s;
                        state_d = (shift_q[6:0] == ADDR) ? ST_ADDR_ACK : ST_IGNORE;
                        busy_d  = (shift_q[6:0] == ADDR) ? busy_q : 1'b0;
                    end
                end
                // The ack phase uses sda_oe_q itself to tell the first fall from the second.
                ST_ADDR_ACK, ST_WR_ACK: if (scl_fall) begin
                    sda_oe_d  = ~sda_oe_q;
                    busy_d    = 1'b1;
                    state_d   = sda_oe_q ? ST_WR_DATA : state_q;
                    bit_cnt_d = 3'd7;
                end
                ST_WR_DATA: if (sample) begin
                    shift_d   = {shift_q[6:0], sda_s};
                    bit_cnt_d = bit_cnt_q - 3'd1;
                    if (bit_cnt_q == 3'd0) begin
                        rx_data_d  = {shift_q[6:0], sda_s};
                        rx_valid_d = 1'b1;
                        state_d    = ST_WR_ACK;
                    end
                end
                ST_RD_DATA: if (scl_fall) begin
                    shift_d   = {shift_q[6:0], 1'b0};
                    sda_oe_d  = (bit_cnt_q == 3'd0) ? 1'b0 : ~shift_q[6];
                    bit_cnt_d = bit_cnt_q - 3'd1;
                    state_d   = (bit_cnt_q == 3'd0) ? ST_RD_ACK : ST_RD_DATA;
                end
                ST_RD_ACK: if (sample && sda_s) begin
                    state_d = ST_IGNORE;
                    busy_d  = 1'b0;
                end
                default: ;
            endcase
        end
    end

    // A read byte is fetched on the fall that ends an address ACK (read) or a controller ACK.
    always_comb begin
        tx_load = scl_fall & ~start & ~stop &
                  ((state_q == ST_ADDR_ACK && sda_oe_q && rw_q == RW_READ) || state_q == ST_RD_ACK);
    end

    assign bus.sda_oe    = sda_oe_q;
    assign bus.rx_data   = rx_data_q;
    assign bus.rx_valid  = rx_valid_q;
    assign bus.tx_req    = tx_load;
    assign bus.busy      = busy_q;
    assign bus.start_det = start;
    assign bus.stop_det  = stop;
endmodule

// File: tb/tb_i2c_target.sv
// tb_i2c_target: bus-level controller model driving the target, with rx/read-byte scoreboards.
module tb_i2c_target;
    import i2c_pkg::*;
    logic clk = 1'b0, rst_n = 1'b0, scl_drv = 1'b1, sda_drv = 1'b1;
    int checks = 0, errors = 0;
    int rx_cnt = 0, tx_cnt = 0, start_cnt = 0, stop_cnt = 0, oe_cnt = 0;
    int tx_idx = 0;
    logic [7:0] tx_mem [16];
    logic [7:0] rx_exp [$];
    logic [7:0] rd_exp [$];

    i2c_target_if bus();
    i2c_target #(.ADDR(7'h50), .SYNC_STAGES(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;
    assign bus.scl_in  = scl_drv;
    assign bus.sda_in  = sda_drv & ~bus.sda_oe;
    assign bus.tx_data = tx_mem[tx_idx[3:0]];
    always @(posedge clk) if (bus.tx_req) tx_idx <= tx_idx + 1;

    always @(negedge clk) begin
        if (bus.tx_req) tx_cnt++;
        if (bus.start_det) start_cnt++;
        if (bus.stop_det) stop_cnt++;
        if (bus.sda_oe) oe_cnt++;
        if (bus.rx_valid) begin
            rx_cnt++;
            checks++;
            if (rx_exp.size() == 0) begin
                errors++;
                $display("FAIL rx_unexpected got %02h expected no rx_valid", bus.rx_data);
            end else begin
                if (bus.rx_data !== rx_exp[0]) begin
                    errors++;
                    $display("FAIL rx_data got %02h expected %02h", bus.rx_data, rx_exp[0]);
                end
                void'(rx_exp.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic hq();
        repeat (8) @(negedge clk);
    endtask
    task automatic bus_start();
        sda_drv = 1'b1; hq(); scl_drv = 1'b1; hq(); sda_drv = 1'b0; hq(); scl_drv = 1'b0; hq();
    endtask
    task automatic bus_stop();
        sda_drv = 1'b0; hq(); scl_drv = 1'b1; hq(); sda_drv = 1'b1; hq();
    endtask
    task automatic put_bit(input logic b);
        sda_drv = b; hq(); scl_drv = 1'b1; hq(); hq(); scl_drv = 1'b0; hq();
    endtask
    task automatic get_bit(output logic b);
        sda_drv = 1'b1; hq(); scl_drv = 1'b1; hq(); b = bus.sda_in; hq(); scl_drv = 1'b0; hq();
    endtask
    task automatic put_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) put_bit(d[i]);
        get_bit(ack);
    endtask
    task automatic get_byte(output logic [7:0] d, input logic ack);
        for (int i = 7; i >= 0; i--) get_bit(d[i]);
        put_bit(ack);
    endtask
    task automatic check_read(input logic [7:0] d, input string name);
        checks++;
        if (rd_exp.size() == 0) begin
            errors++;
            $display("FAIL %s got %02h expected nothing queued", name, d);
        end else begin
            if (d !== rd_exp[0]) begin
                errors++;
                $display("FAIL %s got %02h expected %02h", name, d, rd_exp[0]);
            end
            void'(rd_exp.pop_front());
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (bus.sda_oe !== 1'b0) begin errors++; $display("FAIL rst_sda_oe got %b expected 0", bus.sda_oe); end
        checks++; if (bus.rx_data !== 8'h00) begin errors++; $display("FAIL rst_rx_data got %02h expected 00", bus.rx_data); end
        checks++; if (bus.rx_valid !== 1'b0) begin errors++; $display("FAIL rst_rx_valid got %b expected 0", bus.rx_valid); end
        checks++; if (bus.tx_req !== 1'b0) begin errors++; $display("FAIL rst_tx_req got %b expected 0", bus.tx_req); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b expected 0", bus.busy); end
        checks++; if ({bus.start_det, bus.stop_det} !== 2'b00) begin errors++; $display("FAIL rst_detect got %b expected 00", {bus.start_det, bus.stop_det}); end
        rst_n = 1'b1;
        hq();
    endtask

    task automatic test_write();
        int s0 = stop_cnt, r0 = rx_cnt;
        logic a;
        bus_start();
        put_byte({7'h50, RW_WRITE}, a);
        checks++; if (a !== 1'b0) begin errors++; $display("FAIL wr_addr_ack got %b expected 0", a); end
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL wr_busy got %b expected 1", bus.busy); end
        rx_exp.push_back(8'hA5);
        put_byte(8'hA5, a);
        checks++; if (a !== 1'b0) begin errors++; $display("FAIL wr_data_ack got %b expected 0", a); end
        bus_stop();
        hq();
        checks++; if (rx_cnt - r0 !== 1) begin errors++; $display("FAIL wr_rx_pulses got %0d expected 1", rx_cnt - r0); end
        checks++; if (stop_cnt - s0 !== 1) begin errors++; $display("FAIL wr_stop_pulses got %0d expected 1", stop_cnt - s0); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL wr_busy_end got %b expected 0", bus.busy); end
        checks++; if (bus.rx_data !== 8'hA5) begin errors++; $display("FAIL wr_rx_data got %02h expected a5", bus.rx_data); end
    endtask

    task automatic test_mismatch();
        int o0 = oe_cnt, r0 = rx_cnt;
        logic a;
        bus_start();
        put_byte({7'h51, RW_WRITE}, a);
        checks++; if (a !== 1'b1) begin errors++; $display("FAIL mm_addr_ack got %b expected 1", a); end
        put_byte(8'h3C, a);
        checks++; if (a !== 1'b1) begin errors++; $display("FAIL mm_data_ack got %b expected 1", a); end
        checks++; if (dut.state_q !== ST_IGNORE) begin errors++; $display("FAIL mm_state got %0d expected %0d", dut.state_q, ST_IGNORE); end
        bus_stop();
        hq();
        checks++; if (oe_cnt - o0 !== 0) begin errors++; $display("FAIL mm_sda_oe_cycles got %0d expected 0", oe_cnt - o0); end
        checks++; if (rx_cnt - r0 !== 0) begin errors++; $display("FAIL mm_rx_pulses got %0d expected 0", rx_cnt - r0); end
        checks++; if (dut.state_q !== ST_IDLE) begin errors++; $display("FAIL mm_state_end got %0d expected %0d", dut.state_q, ST_IDLE); end
    endtask

    task automatic test_read();
        int t0 = tx_cnt;
        logic a;
        logic [7:0] d;
        tx_mem[tx_idx % 16] = 8'h96;
        tx_mem[(tx_idx + 1) % 16] = 8'h0F;
        rd_exp.push_back(8'h96);
        rd_exp.push_back(8'h0F);
        bus_start();
        put_byte({7'h50, RW_READ}, a);
        checks++; if (a !== 1'b0) begin errors++; $display("FAIL rd_addr_ack got %b expected 0", a); end
        get_byte(d, 1'b0);
        check_read(d, "rd_byte0");
        get_byte(d, 1'b1);
        check_read(d, "rd_byte1");
        checks++; if (bus.sda_oe !== 1'b0) begin errors++; $display("FAIL rd_nack_oe got %b expected 0", bus.sda_oe); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rd_nack_busy got %b expected 0", bus.busy); end
        checks++; if (tx_cnt - t0 !== 2) begin errors++; $display("FAIL rd_tx_req_pulses got %0d expected 2", tx_cnt - t0); end
        bus_stop();
        hq();
    endtask

    task automatic test_repeated_start();
        int s0 = start_cnt;
        logic a;
        logic [7:0] d;
        bus_start();
        put_byte({7'h50, RW_WRITE}, a);
        checks++; if (a !== 1'b0) begin errors++; $display("FAIL rs_wr_ack got %b expected 0", a); end
        rx_exp.push_back(8'h11);
        put_byte(8'h11, a);
        tx_mem[tx_idx % 16] = 8'hC3;
        rd_exp.push_back(8'hC3);
        bus_start();
        put_byte({7'h50, RW_READ}, a);
        checks++; if (a !== 1'b0) begin errors++; $display("FAIL rs_rd_ack got %b expected 0", a); end
        get_byte(d, 1'b1);
        check_read(d, "rs_read");
        bus_stop();
        hq();
        checks++; if (start_cnt - s0 !== 2) begin errors++; $display("FAIL rs_start_pulses got %0d expected 2", start_cnt - s0); end
        checks++; if (bus.rx_data !== 8'h11) begin errors++; $display("FAIL rs_rx_data got %02h expected 11", bus.rx_data); end
    endtask

    task automatic test_stop_mid();
        int r0 = rx_cnt;
        logic a;
        bus_start();
        put_byte({7'h50, RW_WRITE}, a);
        put_bit(1'b1); put_bit(1'b0); put_bit(1'b1); put_bit(1'b1);
        bus_stop();
        hq();
        checks++; if (rx_cnt - r0 !== 0) begin errors++; $display("FAIL mid_rx_pulses got %0d expected 0", rx_cnt - r0); end
        checks++; if (dut.state_q !== ST_IDLE) begin errors++; $display("FAIL mid_state got %0d expected %0d", dut.state_q, ST_IDLE); end
        checks++; if (bus.sda_oe !== 1'b0) begin errors++; $display("FAIL mid_sda_oe got %b expected 0", bus.sda_oe); end
    endtask

    task automatic test_async_reset();
        logic [7:0] a = {7'h50, RW_WRITE};
        bus_start();
        for (int i = 7; i >= 0; i--) put_bit(a[i]);
        for (int i = 0; i < 20 && bus.sda_oe !== 1'b1; i++) @(negedge clk);
        checks++; if (bus.sda_oe !== 1'b1) begin errors++; $display("FAIL ar_oe_before got %b expected 1", bus.sda_oe); end
        #3 rst_n = 1'b0;
        #1;
        checks++; if (bus.sda_oe !== 1'b0) begin errors++; $display("FAIL ar_sda_oe got %b expected 0", bus.sda_oe); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL ar_busy got %b expected 0", bus.busy); end
        checks++; if (bus.rx_data !== 8'h00) begin errors++; $display("FAIL ar_rx_data got %02h expected 00", bus.rx_data); end
        checks++; if ({bus.rx_valid, bus.tx_req, bus.start_det, bus.stop_det} !== 4'b0000) begin
            errors++; $display("FAIL ar_strobes got %b expected 0000", {bus.rx_valid, bus.tx_req, bus.start_det, bus.stop_det});
        end
        checks++; if (dut.state_q !== ST_IDLE) begin errors++; $display("FAIL ar_state got %0d expected %0d", dut.state_q, ST_IDLE); end
        scl_drv = 1'b1;
        sda_drv = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        hq();
    endtask

    initial begin
        test_reset();
        test_write();
        test_mismatch();
        test_read();
        test_repeated_start();
        test_stop_mid();
        test_async_reset();
        checks++;
        if (rx_exp.size() != 0) begin errors++; $display("FAIL rx_leftover got %0d expected 0", rx_exp.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
